// File: rtl/aclk_key_entry.sv
// Keypad entry stage: collects HH:MM digits and issues alarm/clock load strobes.
// Optional macro ACLK_TIME_CHECK_EN enables time validation and entry_error.
module aclk_key_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic [3:0] new_alarm_ms_hr,
  output logic [3:0] new_alarm_ls_hr,
  output logic [3:0] new_alarm_ms_min,
  output logic [3:0] new_alarm_ls_min,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       entry_error,
  output logic       entry_active,
  output logic [2:0] digit_count
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_LOAD,
    S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [3:0][3:0] digits_q, digits_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [CntW-1:0] idle_q, idle_d;
  logic            load_a_q, load_a_d;
  logic            load_c_q, load_c_d;
  logic            err_q, err_d;
  logic            active_q, active_d;

  logic is_digit, is_cmd, time_ok;

  assign is_digit = key_valid && (key <= 4'd9);
  assign is_cmd   = key_valid && ((key == 4'hA) || (key == 4'hB));

  // Buffer must form a legal 24h time with all four digits entered
`ifdef ACLK_TIME_CHECK_EN
  assign time_ok = (digits_q[3] <= 4'd2) &&
                   ((digits_q[3] != 4'd2) || (digits_q[2] <= 4'd3)) &&
                   (digits_q[1] <= 4'd5) &&
                   (digits_q[0] <= 4'd9) &&
                   (cnt_q == 3'd4);
`else
  assign time_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      digits_q <= '0;
      cnt_q    <= '0;
      idle_q   <= '0;
      load_a_q <= 1'b0;
      load_c_q <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      load_a_q <= load_a_d;
      load_c_q <= load_c_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    idle_d   = '0;
    load_a_d = 1'b0;
    load_c_d = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (is_digit) begin
          digits_d = {12'h000, key};
          cnt_d    = 3'd1;
          state_d  = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (is_digit) begin
          digits_d = {digits_q[2:0], key};
          cnt_d    = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
        end else if (is_cmd) begin
          if (time_ok) begin
            state_d  = S_LOAD;
            load_a_d = (key == 4'hA);
            load_c_d = (key == 4'hB);
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end else if (idle_q == CntLast) begin
          // A key on the expiry edge takes the branches above instead
          digits_d = '0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          idle_d = idle_q + CntW'(1);
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        digits_d = '0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    active_d = (state_d == S_ENTRY);
  end

  assign new_alarm_ms_hr  = digits_q[3];
  assign new_alarm_ls_hr  = digits_q[2];
  assign new_alarm_ms_min = digits_q[1];
  assign new_alarm_ls_min = digits_q[0];
  assign load_new_a       = load_a_q;
  assign load_new_c       = load_c_q;
  assign entry_error      = err_q;
  assign entry_active     = active_q;
  assign digit_count      = cnt_q;

endmodule

// File: tb/tb_aclk_key_entry.sv
// Randomized and plan-driven bench for aclk_key_entry against a value-level model.
module tb_aclk_key_entry;

  localparam int unsigned T = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_new_a, load_new_c, entry_error, entry_active;
  logic [2:0] digit_count;

  always #5 clk = ~clk;

  aclk_key_entry #(.TIMEOUT_CYCLES(T)) dut (
    .clk              (clk),
    .reset            (reset),
    .key_valid        (key_valid),
    .key              (key),
    .new_alarm_ms_hr  (ms_hr),
    .new_alarm_ls_hr  (ls_hr),
    .new_alarm_ms_min (ms_min),
    .new_alarm_ls_min (ls_min),
    .load_new_a       (load_new_a),
    .load_new_c       (load_new_c),
    .entry_error      (entry_error),
    .entry_active     (entry_active),
    .digit_count      (digit_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: the entry is a decimal number 0..9999; phase 0 idle, 1 entry, 2 load, 3 error
  int m_phase = 0;
  int m_val   = 0;
  int m_cnt   = 0;
  int m_edge  = 0;
  int m_last  = 0;
  bit m_a, m_c, m_e;

  function automatic bit time_ok(input int v, input int c);
`ifdef ACLK_TIME_CHECK_EN
    return (c == 4) && (v / 100 <= 23) && (v % 100 <= 59);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_edge(input bit r, input bit kv, input int k);
    m_edge++;
    m_a = 0; m_c = 0; m_e = 0;
    if (r) begin
      m_phase = 0; m_val = 0; m_cnt = 0;
      return;
    end
    case (m_phase)
      0: if (kv && k <= 9) begin
        m_val = k; m_cnt = 1; m_phase = 1; m_last = m_edge;
      end
      1: begin
        if (kv && k <= 9) begin
          m_val = (m_val * 10 + k) % 10000;
          m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
          m_last = m_edge;
        end else if (kv && (k == 10 || k == 11)) begin
          m_last = m_edge;
          if (time_ok(m_val, m_cnt)) begin
            m_phase = 2; m_a = (k == 10); m_c = (k == 11);
          end else begin
            m_phase = 3; m_e = 1;
          end
        end else if (m_edge - m_last >= T) begin
          m_val = 0; m_cnt = 0; m_phase = 0;
        end
      end
      2: begin m_cnt = 0; m_phase = 0; end
      default: begin m_val = 0; m_cnt = 0; m_phase = 0; end
    endcase
  endtask

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic step(input bit r, input bit kv, input int k);
    reset = r; key_valid = kv; key = 4'(k);
    @(posedge clk);
    model_edge(r, kv, k);
    #1;
    check_eq("digits", {ms_hr, ls_hr, ms_min, ls_min}, bcd(m_val));
    check_eq("load_a", 16'(load_new_a), 16'(m_a));
    check_eq("load_c", 16'(load_new_c), 16'(m_c));
    check_eq("error", 16'(entry_error), 16'(m_e));
    check_eq("active", 16'(entry_active), 16'(m_phase == 1));
    check_eq("count", 16'(digit_count), 16'(m_cnt));
  endtask

  task automatic press(input int k);
    step(0, 1, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0);
    step(1, 0, 0);
    check_eq("reset_digits", {ms_hr, ls_hr, ms_min, ls_min}, 16'h0000);

    press(1); press(2); press(3); press(0); press(10);
    check_eq("plan1_strobe", 16'(load_new_a), 16'h1);
    idle(1);
    check_eq("plan1_buf", {ms_hr, ls_hr, ms_min, ls_min}, 16'h1230);
    check_eq("plan1_cnt", 16'(digit_count), 16'h0);

    press(0); press(7); press(4); press(5); press(11);
    check_eq("plan2_c", 16'(load_new_c), 16'h1);
    idle(1);
    check_eq("plan2_buf", {ms_hr, ls_hr, ms_min, ls_min}, 16'h0745);

    press(9); press(1); press(2); press(3); press(4);
    check_eq("plan3_cnt", 16'(digit_count), 16'h4);
    press(10);
    idle(1);
    check_eq("plan3_buf", {ms_hr, ls_hr, ms_min, ls_min}, 16'h1234);

    press(2); press(4); press(0); press(0); press(10);
    idle(1);
`ifdef ACLK_TIME_CHECK_EN
    check_eq("plan4_buf", {ms_hr, ls_hr, ms_min, ls_min}, 16'h0000);
`else
    check_eq("plan4_buf", {ms_hr, ls_hr, ms_min, ls_min}, 16'h2400);
`endif

    press(1); press(2); idle(T - 1);
    check_eq("plan5_alive", 16'(entry_active), 16'h1);
    idle(1);
    check_eq("plan5_expired", 16'(entry_active), 16'h0);
    check_eq("plan5_buf", {ms_hr, ls_hr, ms_min, ls_min}, 16'h0000);
    press(1); press(2); idle(T - 1); press(3);
    check_eq("plan5_race", {ms_hr, ls_hr, ms_min, ls_min}, 16'h0123);
    idle(T);

    press(1); press(2); step(1, 1, 10);
    check_eq("plan6_rst", {ms_hr, ls_hr, ms_min, ls_min, 1'b0, load_new_a, digit_count}, 16'h0);
    step(0, 0, 0);
    press(10);
    check_eq("plan6_idle_cmd", {14'h0, load_new_a, entry_error}, 16'h0);

    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if ($urandom_range(0, 299) == 0) step(1, 0, 0);
      else if (sel < 8) idle(int'($urandom_range(T - 2, T + 2)));
      else if (sel < 30) step(0, 0, 0);
      else if (sel < 75) press(int'($urandom_range(0, 9)));
      else if (sel < 88) press(int'($urandom_range(10, 11)));
      else press(int'($urandom_range(12, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/aclk_key_entry.md
Name: aclk_key_entry

Overview:
Keypad entry stage of the alarm clock. It sits directly upstream of the alarm register and accumulates keypad digits into a 4-digit HH:MM buffer. On the ALARM key it validates the buffer and issues a one-cycle load_new_a strobe; on the TIME key it issues load_new_c for the clock time register. An abandoned entry is dropped after a programmable idle timeout.

Parameters:
TIMEOUT_CYCLES, 10, clk cycles without a key press in ENTRY before the entry is abandoned (minimum 2).

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
key_valid  input  1  one-cycle strobe, key is valid this cycle
key  input  4  key code: 0-9 digit, 4'hA ALARM, 4'hB TIME, 4'hC-4'hF ignored
new_alarm_ms_hr  output  4  buffer digit 3, hour tens
new_alarm_ls_hr  output  4  buffer digit 2, hour units
new_alarm_ms_min  output  4  buffer digit 1, minute tens
new_alarm_ls_min  output  4  buffer digit 0, minute units
load_new_a  output  1  one-cycle load strobe for the alarm register
load_new_c  output  1  one-cycle load strobe for the clock time register
entry_error  output  1  one-cycle strobe, command rejected
entry_active  output  1  high while in ENTRY
digit_count  output  3  digits entered this entry, saturates at 4

Behaviour:
- Reset: every output is 0, including all four digits. State is IDLE. idle_cnt is 0.
- States: IDLE, ENTRY, LOAD, ERR. All outputs are registered.
- Digit key (0-9) accepted at edge N; the new value is visible from cycle N+1.
  - In IDLE or LOAD/ERR-exit: buffer becomes {0,0,0,key}, digit_count becomes 1, state goes to ENTRY.
  - In ENTRY: buffer shifts left (ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key). digit_count increments and saturates at 4. The oldest digit is dropped on a 5th or later digit.
- Command key (A or B) in ENTRY at edge N:
  - If accepted: go to LOAD. The matching strobe (A -> load_new_a, B -> load_new_c) is high for exactly cycle N+1.
  - At edge N+1: return to IDLE, digit_count becomes 0. The buffer is retained unchanged, so the downstream register sees stable data during and after the strobe.
- Command key in IDLE (digit_count 0): ignored, no strobe.
- Keys 4'hC-4'hF: ignored in every state and do not reset idle_cnt.
- key_valid during LOAD or ERR: ignored.
- Validity (when checked): ms_hr<=2; if ms_hr==2 then ls_hr<=3; ms_min<=5; ls_min<=9; digit_count==4.
- Rejected command: go to ERR. entry_error is high for cycle N+1, no load strobe. At edge N+1: buffer is cleared to 0000, digit_count becomes 0, state goes to IDLE.
- Timeout: idle_cnt is cleared on each accepted digit/command and increments each ENTRY cycle without a key.
  - If the last key was at edge N, then at edge N+TIMEOUT_CYCLES the buffer clears to 0000, digit_count becomes 0, and state goes to IDLE. No strobe.
  - A key arriving at the expiry edge wins over the timeout.
- entry_active is 1 exactly while state==ENTRY.
- Reset mid-entry or during LOAD: all outputs return to reset values on the next edge, and any pending strobe is cancelled.
- idle_cnt width is $clog2(TIMEOUT_CYCLES+1).

Optional Feature:
ACLK_TIME_CHECK_EN
- Defined: the validity check above applies, and entry_error is generated.
- Not defined: every command in ENTRY is accepted and loads the buffer as-is, with leading zeros if fewer than 4 digits were entered. ERR is unreachable and entry_error is tied 0.

Test Plan:
- Reset, then keys 1,2,3,0,A one per cycle -> digits 1,2,3,0; load_new_a high for exactly one cycle after A; digit_count 0; buffer still 1230 afterwards.
- Keys 0,7,4,5,B -> load_new_c single-cycle pulse, load_new_a stays 0; buffer 0745.
- Keys 9,1,2,3,4,A -> buffer 1234 (9 dropped), digit_count held at 4, load_new_a pulse.
- With ACLK_TIME_CHECK_EN, keys 2,4,0,0,A -> entry_error one cycle, no load, buffer 0000. Without the macro -> load_new_a pulse, buffer 2400.
- TIMEOUT_CYCLES=10, keys 1,2 then idle -> entry_active drops and buffer 0000 exactly 10 cycles after key 2. A digit on cycle 10 instead -> buffer 0123, no timeout.
- Keys 1,2, then reset asserted in the same cycle as A -> no strobe; all outputs 0 the next cycle. Key A in IDLE -> no strobe, no error.
